// File: rtl/cnn_mem_rd_arb_if.sv
// ---------------------------------------------------------------------------
// cnn_mem_rd_arb_if
// Memory read channel between the CNN read arbiter and the memory.
//
//   mem_req         master->slave  read request, high for the whole transaction
//   mem_start_addr  master->slave  start byte address, held while mem_req is high
//   mem_size_bytes  master->slave  transaction byte count, held while mem_req is high
//   mem_valid       slave->master  data beat valid
//   mem_last        slave->master  current beat is the transaction's last
//   mem_data        slave->master  beat data
//   mem_last_valid  slave->master  index of the last valid byte in the beat
//
// Modports: master (arbiter side), slave (memory side).
// ---------------------------------------------------------------------------
interface cnn_mem_rd_arb_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_BYTES = 32,
    parameter int SIZE_WIDTH = 8
);
    logic                          mem_req;
    logic [ADDR_WIDTH-1:0]         mem_start_addr;
    logic [SIZE_WIDTH-1:0]         mem_size_bytes;
    logic                          mem_valid;
    logic                          mem_last;
    logic [DATA_BYTES*8-1:0]       mem_data;
    logic [$clog2(DATA_BYTES)-1:0] mem_last_valid;

    modport master (
        output mem_req, mem_start_addr, mem_size_bytes,
        input  mem_valid, mem_last, mem_data, mem_last_valid
    );

    modport slave (
        input  mem_req, mem_start_addr, mem_size_bytes,
        output mem_valid, mem_last, mem_data, mem_last_valid
    );
endinterface

// File: rtl/cnn_mem_rd_arb.sv
// ---------------------------------------------------------------------------
// cnn_mem_rd_arb
// Shares the CNN's single memory read port between three requesters
// (pic, wgt, bias). A winner's address/size are latched in IDLE; the winner
// owns the port until its last beat, and only the owner sees valid strobes.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   <r>_req / <r>_addr / <r>_size request, start byte address, byte count
//   <r>_valid                     data beat valid for requester <r>
//   rd_data / rd_last / rd_last_valid  broadcast beat data, last flag, last byte index
//   arb_busy                      a transaction is outstanding
//   arb_owner                     0 none, 1 pic, 2 wgt, 3 bias
//   mem                           memory read channel (master modport)
//
// Build option: define CNN_RD_ARB_RR_EN for round-robin arbitration
// (pic -> wgt -> bias -> pic, starting after the last owner). Without it the
// policy is fixed priority bias > wgt > pic.
// ---------------------------------------------------------------------------
module cnn_mem_rd_arb #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_BYTES = 32,
    parameter int SIZE_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pic_req,
    input  logic                          wgt_req,
    input  logic                          bias_req,
    input  logic [ADDR_WIDTH-1:0]         pic_addr,
    input  logic [ADDR_WIDTH-1:0]         wgt_addr,
    input  logic [ADDR_WIDTH-1:0]         bias_addr,
    input  logic [SIZE_WIDTH-1:0]         pic_size,
    input  logic [SIZE_WIDTH-1:0]         wgt_size,
    input  logic [SIZE_WIDTH-1:0]         bias_size,
    output logic                          pic_valid,
    output logic                          wgt_valid,
    output logic                          bias_valid,
    output logic                          rd_last,
    output logic [DATA_BYTES*8-1:0]       rd_data,
    output logic [$clog2(DATA_BYTES)-1:0] rd_last_valid,
    output logic                          arb_busy,
    output logic [1:0]                    arb_owner,
    cnn_mem_rd_arb_if.master              mem
);

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_PIC = 2'd1, OWN_WGT = 2'd2, OWN_BIAS = 2'd3} owner_e;

    state_e                state;
    owner_e                owner;
    owner_e                winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [SIZE_WIDTH-1:0] win_size;
`ifdef CNN_RD_ARB_RR_EN
    owner_e                rr_last;   // owner of the most recently completed transaction
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        winner   = OWN_NONE;
        win_addr = '0;
        win_size = '0;
`ifdef CNN_RD_ARB_RR_EN
        // Search starts at the requester after the previous owner.
        case (rr_last)
            OWN_PIC: begin
                if      (wgt_req)  winner = OWN_WGT;
                else if (bias_req) winner = OWN_BIAS;
                else if (pic_req)  winner = OWN_PIC;
            end
            OWN_WGT: begin
                if      (bias_req) winner = OWN_BIAS;
                else if (pic_req)  winner = OWN_PIC;
                else if (wgt_req)  winner = OWN_WGT;
            end
            default: begin
                if      (pic_req)  winner = OWN_PIC;
                else if (wgt_req)  winner = OWN_WGT;
                else if (bias_req) winner = OWN_BIAS;
            end
        endcase
`else
        if      (bias_req) winner = OWN_BIAS;
        else if (wgt_req)  winner = OWN_WGT;
        else if (pic_req)  winner = OWN_PIC;
`endif
        case (winner)
            OWN_PIC:  begin win_addr = pic_addr;  win_size = pic_size;  end
            OWN_WGT:  begin win_addr = wgt_addr;  win_size = wgt_size;  end
            OWN_BIAS: begin win_addr = bias_addr; win_size = bias_size; end
            default:  begin win_addr = '0;        win_size = '0;        end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous and takes effect at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            owner              <= OWN_NONE;
            mem.mem_req        <= 1'b0;
            mem.mem_start_addr <= '0;
            mem.mem_size_bytes <= '0;
`ifdef CNN_RD_ARB_RR_EN
            rr_last            <= OWN_BIAS;   // pic searched first after reset
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (winner != OWN_NONE) begin
                        state              <= BUSY;
                        owner              <= winner;
                        mem.mem_req        <= 1'b1;
                        mem.mem_start_addr <= win_addr;
                        mem.mem_size_bytes <= win_size;
                    end
                end
                BUSY: begin
                    // Requester inputs are ignored until the owner's last beat.
                    if (mem.mem_valid && mem.mem_last) begin
                        state       <= IDLE;
                        owner       <= OWN_NONE;
                        mem.mem_req <= 1'b0;
`ifdef CNN_RD_ARB_RR_EN
                        rr_last     <= owner;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb_busy  = (state == BUSY);
    assign arb_owner = owner;

    // Beats arriving while IDLE are dropped: owner is OWN_NONE there.
    assign pic_valid  = mem.mem_valid && (state == BUSY) && (owner == OWN_PIC);
    assign wgt_valid  = mem.mem_valid && (state == BUSY) && (owner == OWN_WGT);
    assign bias_valid = mem.mem_valid && (state == BUSY) && (owner == OWN_BIAS);

    assign rd_data       = mem.mem_data;
    assign rd_last       = mem.mem_last & mem.mem_valid;
    assign rd_last_valid = mem.mem_last_valid;

endmodule

// File: tb/tb_cnn_mem_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_cnn_mem_rd_arb
// Self-checking bench for cnn_mem_rd_arb: directed scenarios with literal
// expectations, then randomized requesters and memory responses compared
// every cycle against a transaction-level model of the arbiter.
// Honours CNN_RD_ARB_RR_EN for the expected arbitration order.
// ---------------------------------------------------------------------------
module tb_cnn_mem_rd_arb;
    localparam int AW = 19;
    localparam int DB = 32;
    localparam int SW = 8;
    localparam int DW = DB * 8;
    localparam int LW = $clog2(DB);

    logic          clk = 1'b0;
    logic          rst;
    logic          pic_req, wgt_req, bias_req;
    logic [AW-1:0] pic_addr, wgt_addr, bias_addr;
    logic [SW-1:0] pic_size, wgt_size, bias_size;
    logic          pic_valid, wgt_valid, bias_valid, rd_last;
    logic [DW-1:0] rd_data;
    logic [LW-1:0] rd_last_valid;
    logic          arb_busy;
    logic [1:0]    arb_owner;

    cnn_mem_rd_arb_if #(.ADDR_WIDTH(AW), .DATA_BYTES(DB), .SIZE_WIDTH(SW)) mem_if ();

    cnn_mem_rd_arb #(.ADDR_WIDTH(AW), .DATA_BYTES(DB), .SIZE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .pic_req(pic_req), .wgt_req(wgt_req), .bias_req(bias_req),
        .pic_addr(pic_addr), .wgt_addr(wgt_addr), .bias_addr(bias_addr),
        .pic_size(pic_size), .wgt_size(wgt_size), .bias_size(bias_size),
        .pic_valid(pic_valid), .wgt_valid(wgt_valid), .bias_valid(bias_valid),
        .rd_last(rd_last), .rd_data(rd_data), .rd_last_valid(rd_last_valid),
        .arb_busy(arb_busy), .arb_owner(arb_owner),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int            m_owner;       // 0 none, 1 pic, 2 wgt, 3 bias
    int            m_done_owner;  // requester whose last beat was taken at the latest edge
    logic [AW-1:0] m_addr;
    logic [SW-1:0] m_size;
`ifdef CNN_RD_ARB_RR_EN
    int            m_rr_last;
`endif

    function automatic bit req_of(input int x);
        case (x)
            1: return pic_req;
            2: return wgt_req;
            3: return bias_req;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_of(input int x);
        return (x == 1) ? pic_addr : (x == 2) ? wgt_addr : bias_addr;
    endfunction

    function automatic logic [SW-1:0] size_of(input int x);
        return (x == 1) ? pic_size : (x == 2) ? wgt_size : bias_size;
    endfunction

    function automatic int pick();
`ifdef CNN_RD_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_rr_last - 1 + k) % 3 + 1;
            if (req_of(c)) return c;
        end
`else
        for (int c = 3; c >= 1; c--)
            if (req_of(c)) return c;
`endif
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner      <= 0;
            m_done_owner <= 0;
            m_addr       <= '0;
            m_size       <= '0;
`ifdef CNN_RD_ARB_RR_EN
            m_rr_last    <= 3;
`endif
        end else begin
            m_done_owner <= 0;
            if (m_owner != 0) begin
                if (mem_if.mem_valid && mem_if.mem_last) begin
                    m_done_owner <= m_owner;
                    m_owner      <= 0;
`ifdef CNN_RD_ARB_RR_EN
                    m_rr_last    <= m_owner;
`endif
                end
            end else if (pick() != 0) begin
                m_owner <= pick();
                m_addr  <= addr_of(pick());
                m_size  <= size_of(pick());
            end
        end
    end

    // ---------------- per-cycle compare + grant log ----------------
    int            cyc = 0;
    logic          prev_req = 1'b0;
    int            grants[$];
    int            rise_cyc[$];
    logic [AW-1:0] g_addr[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("mem_req",        mem_if.mem_req,        m_owner != 0);
        check("arb_busy",       arb_busy,              m_owner != 0);
        check("arb_owner",      arb_owner,             m_owner);
        check("mem_start_addr", mem_if.mem_start_addr, m_addr);
        check("mem_size_bytes", mem_if.mem_size_bytes, m_size);
        check("pic_valid",      pic_valid,             mem_if.mem_valid && m_owner == 1);
        check("wgt_valid",      wgt_valid,             mem_if.mem_valid && m_owner == 2);
        check("bias_valid",     bias_valid,            mem_if.mem_valid && m_owner == 3);
        check("rd_last",        rd_last,               mem_if.mem_last && mem_if.mem_valid);
        check("rd_data",        rd_data,               mem_if.mem_data);
        check("rd_last_valid",  rd_last_valid,         mem_if.mem_last_valid);
        if (mem_if.mem_req && !prev_req) begin
            grants.push_back(int'(arb_owner));
            rise_cyc.push_back(cyc);
            g_addr.push_back(mem_if.mem_start_addr);
        end
        prev_req <= mem_if.mem_req;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic raise(input int x, input logic [AW-1:0] a, input logic [SW-1:0] s);
        case (x)
            1: begin pic_req  = 1'b1; pic_addr  = a; pic_size  = s; end
            2: begin wgt_req  = 1'b1; wgt_addr  = a; wgt_size  = s; end
            3: begin bias_req = 1'b1; bias_addr = a; bias_size = s; end
            default: ;
        endcase
    endtask

    task automatic drop(input int x);
        case (x)
            1: pic_req  = 1'b0;
            2: wgt_req  = 1'b0;
            3: bias_req = 1'b0;
            default: ;
        endcase
    endtask

    task automatic idle_all();
        pic_req = 0; wgt_req = 0; bias_req = 0;
        pic_addr = '0; wgt_addr = '0; bias_addr = '0;
        pic_size = '0; wgt_size = '0; bias_size = '0;
        mem_if.mem_valid = 0; mem_if.mem_last = 0;
        mem_if.mem_data = '0; mem_if.mem_last_valid = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        grants.delete();
        rise_cyc.delete();
        g_addr.delete();
    endtask

    // Waits (bounded) for mem_req, then returns `beats` beats; the owner
    // drops its request after its last beat unless hold is set.
    task automatic serve(input int beats, input bit hold);
        int who;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_if.mem_req) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            check("grant_timeout", mem_if.mem_req, 1'b1);
            return;
        end
        who = 0;
        for (int b = 1; b <= beats; b++) begin
            mem_if.mem_valid      = 1'b1;
            mem_if.mem_last       = (b == beats);
            mem_if.mem_data       = rand_data();
            mem_if.mem_last_valid = LW'($urandom);
            #1;
            who = pic_valid ? 1 : wgt_valid ? 2 : bias_valid ? 3 : 0;
            step();
        end
        mem_if.mem_valid = 1'b0;
        mem_if.mem_last  = 1'b0;
        if (!hold) drop(who);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[3];
        rst = 1'b1;
        idle_all();

        // ---- single pic transaction, 3 beats ----
        do_reset();
        check("reset mem_req", mem_if.mem_req, 1'b0);
        check("reset arb_owner", arb_owner, 2'd0);
        raise(1, 19'h1C, 8'd5);
        step();
        check("t1 mem_req", mem_if.mem_req, 1'b1);
        check("t1 addr", mem_if.mem_start_addr, 19'h1C);
        check("t1 size", mem_if.mem_size_bytes, 8'd5);
        check("t1 owner", arb_owner, 2'd1);
        for (int b = 1; b <= 3; b++) begin
            mem_if.mem_valid = 1'b1;
            mem_if.mem_last  = (b == 3);
            mem_if.mem_data  = rand_data();
            #1;
            check("t1 pic_valid", pic_valid, 1'b1);
            check("t1 wgt_valid", wgt_valid, 1'b0);
            check("t1 rd_last", rd_last, b == 3);
            step();
        end
        pic_req = 1'b0;
        mem_if.mem_valid = 1'b0;
        mem_if.mem_last  = 1'b0;
        #1;
        check("t1 mem_req after last", mem_if.mem_req, 1'b0);
        check("t1 owner after last", arb_owner, 2'd0);

        // ---- simultaneous requests ----
        do_reset();
        raise(1, 19'h000, 8'd32);
        raise(2, 19'h400, 8'd32);
        raise(3, 19'h800, 8'd32);
        for (int i = 0; i < 3; i++) serve(1, 1'b0);
        step();
        step();
`ifdef CNN_RD_ARB_RR_EN
        exp_order = '{1, 2, 3};
`else
        exp_order = '{3, 2, 1};
`endif
        check("t2 grant count", grants.size(), 3);
        for (int i = 0; i < grants.size() && i < 3; i++) begin
            check("t2 grant order", grants[i], exp_order[i]);
            check("t2 grant addr", g_addr[i], AW'((exp_order[i] - 1) * 'h400));
            if (i > 0) check("t2 grant spacing", rise_cyc[i] - rise_cyc[i-1], 2);
        end

        // ---- pic and wgt held high for 6 transactions ----
        do_reset();
        raise(1, 19'h100, 8'd64);
        raise(2, 19'h200, 8'd64);
        for (int i = 0; i < 6; i++) serve(2, 1'b1);
        drop(1);
        drop(2);
        step();
        step();
        check("t3 grant count", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++) begin
`ifdef CNN_RD_ARB_RR_EN
            check("t3 grant order", grants[i], (i % 2 == 0) ? 1 : 2);
`else
            check("t3 grant order", grants[i], 2);
`endif
        end

        // ---- inputs change during a wgt transaction ----
        do_reset();
        raise(2, 19'h123, 8'd64);
        step();
        check("t4 owner", arb_owner, 2'd2);
        for (int b = 1; b <= 4; b++) begin
            if (b == 1) begin
                wgt_addr = 19'h3FF;
                raise(3, 19'h7000, 8'd9);
            end
            mem_if.mem_valid = 1'b1;
            mem_if.mem_last  = (b == 4);
            #1;
            check("t4 addr held", mem_if.mem_start_addr, 19'h123);
            check("t4 wgt_valid", wgt_valid, 1'b1);
            check("t4 bias_valid", bias_valid, 1'b0);
            step();
        end
        wgt_req = 1'b0;
        mem_if.mem_valid = 1'b0;
        mem_if.mem_last  = 1'b0;
        check("t4 dead cycle", mem_if.mem_req, 1'b0);
        step();
        check("t4 bias granted", arb_owner, 2'd3);
        check("t4 bias addr", mem_if.mem_start_addr, 19'h7000);
        check("t4 bias size", mem_if.mem_size_bytes, 8'd9);
        serve(1, 1'b0);

        // ---- mem_valid while idle ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_if.mem_valid = 1'b1;
            mem_if.mem_last  = (i == 2);
            #1;
            check("t5 pic_valid", pic_valid, 1'b0);
            check("t5 wgt_valid", wgt_valid, 1'b0);
            check("t5 bias_valid", bias_valid, 1'b0);
            step();
            check("t5 mem_req", mem_if.mem_req, 1'b0);
            check("t5 owner", arb_owner, 2'd0);
        end
        mem_if.mem_valid = 1'b0;
        mem_if.mem_last  = 1'b0;

        // ---- reset in the middle of a transaction ----
        do_reset();
        raise(1, 19'h40, 8'd128);
        step();
        mem_if.mem_valid = 1'b1;
        step();
        #1;
        check("t6 beat2 pic_valid", pic_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("t6 rst mem_req", mem_if.mem_req, 1'b0);
        check("t6 rst busy", arb_busy, 1'b0);
        check("t6 rst owner", arb_owner, 2'd0);
        check("t6 rst addr", mem_if.mem_start_addr, 19'h0);
        check("t6 rst size", mem_if.mem_size_bytes, 8'd0);
        check("t6 rst pic_valid", pic_valid, 1'b0);
        pic_req = 1'b0;
        mem_if.mem_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        raise(1, 19'h80, 8'd16);
        step();
        check("t6 regrant", mem_if.mem_req, 1'b1);
        check("t6 regrant addr", mem_if.mem_start_addr, 19'h80);
        check("t6 regrant owner", arb_owner, 2'd1);
        serve(1, 1'b0);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int x = 1; x <= 3; x++) begin
                if (m_done_owner == x) drop(x);
                else if (!req_of(x) && ($urandom % 4 == 0))
                    raise(x, AW'($urandom), SW'($urandom));
                else if (req_of(x) && m_owner == x && ($urandom % 16 == 0))
                    drop(x);
                else if (req_of(x) && m_owner == x && ($urandom % 8 == 0))
                    raise(x, AW'($urandom), size_of(x));
            end
            if (m_owner != 0) begin
                mem_if.mem_valid = ($urandom % 3 != 0);
                mem_if.mem_last  = mem_if.mem_valid && ($urandom % 4 == 0);
            end else begin
                mem_if.mem_valid = ($urandom % 8 == 0);
                mem_if.mem_last  = 1'($urandom);
            end
            mem_if.mem_data       = rand_data();
            mem_if.mem_last_valid = LW'($urandom);
            step();
        end
        idle_all();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
